// File: rtl/sha2_msg_scheduler_if.sv
// Load port (block buffer -> scheduler) and word stream (scheduler -> compression core).
// The scheduler uses the slave view; the block buffer/consumer side uses the master view.
interface sha2_msg_scheduler_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 7
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              w_valid;
  logic              w_ready;
  logic [WORD_W-1:0] w_data;
  logic [IDX_W-1:0]  w_idx;

  modport slave (
    input  in_valid, in_data, w_ready,
    output in_ready, w_valid, w_data, w_idx
  );

  modport master (
    output in_valid, in_data, w_ready,
    input  in_ready, w_valid, w_data, w_idx
  );
endinterface

// File: rtl/sha2_msg_scheduler.sv
// SHA-256/SHA-512 message-schedule generator built on a 16-word sliding window.
// Define MSCHED_BSWAP_EN to byte-reverse load words coming from little-endian sources.
module sha2_msg_scheduler #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clr,
  sha2_msg_scheduler_if.slave        bus,
  output logic                       busy,
  output logic                       blk_done
);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("sha2_msg_scheduler: WORD_W must be 32 or 64");
    end
    if (ROUNDS != 64 && ROUNDS != 80) begin : g_bad_rounds
      $error("sha2_msg_scheduler: ROUNDS must be 64 or 80");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_LOAD  = IDX_W'(15);
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);

  state_t            state, state_nx;
  logic [WORD_W-1:0] win [16];
  logic [IDX_W-1:0]  cnt;
  logic              w_valid_q;
  logic [WORD_W-1:0] w_data_q;
  logic [IDX_W-1:0]  w_idx_q;
  logic              done_q;

  logic [WORD_W-1:0] din;
  logic [WORD_W-1:0] s0, s1, new_w, shift_in;
  logic              adv, load_xfer, issue, drain_xfer, shift_en;

`ifdef MSCHED_BSWAP_EN
  always_comb begin
    din = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      din[8*b +: 8] = bus.in_data[WORD_W-8-8*b +: 8];
    end
  end
`else
  assign din = bus.in_data;
`endif

  generate
    if (WORD_W == 64) begin : g_sigma512
      assign s0 = {win[1][0], win[1][WORD_W-1:1]} ^ {win[1][7:0], win[1][WORD_W-1:8]}
                ^ (win[1] >> 7);
      assign s1 = {win[14][18:0], win[14][WORD_W-1:19]} ^ {win[14][60:0], win[14][WORD_W-1:61]}
                ^ (win[14] >> 6);
    end else begin : g_sigma256
      assign s0 = {win[1][6:0], win[1][WORD_W-1:7]} ^ {win[1][17:0], win[1][WORD_W-1:18]}
                ^ (win[1] >> 3);
      assign s1 = {win[14][16:0], win[14][WORD_W-1:17]} ^ {win[14][18:0], win[14][WORD_W-1:19]}
                ^ (win[14] >> 10);
    end
  endgenerate

  assign new_w = s1 + win[9] + s0 + win[0];

  // An abort must not look like an accepted word to the block buffer, so clr masks in_ready.
  assign adv         = !w_valid_q || bus.w_ready;
  assign bus.in_ready = (state == LOAD) && adv && !clr;
  assign load_xfer   = bus.in_valid && bus.in_ready;
  assign issue       = (state == EXPAND) && adv && !clr;
  assign drain_xfer  = (state == DRAIN) && w_valid_q && bus.w_ready && !clr;
  assign shift_en    = load_xfer || issue;
  assign shift_in    = (state == LOAD) ? din : new_w;

  assign bus.w_valid = w_valid_q;
  assign bus.w_data  = w_data_q;
  assign bus.w_idx   = w_idx_q;
  assign busy        = (state != IDLE);
  assign blk_done    = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = LOAD;
        LOAD:    if (load_xfer && cnt == LAST_LOAD) state_nx = EXPAND;
        EXPAND:  if (issue && cnt == LAST_ROUND) state_nx = DRAIN;
        DRAIN:   if (drain_xfer) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // The window is left untouched by clr: the next LOAD overwrites all 16 entries anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= shift_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_idx_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clr) begin
        w_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) cnt <= '0;
          end
          LOAD, EXPAND: begin
            if (shift_en) begin
              w_data_q  <= shift_in;
              w_idx_q   <= cnt;
              w_valid_q <= 1'b1;
              cnt       <= cnt + IDX_W'(1);
            end else if (state == LOAD && bus.w_ready) begin
              w_valid_q <= 1'b0;
            end
          end
          DRAIN: begin
            if (drain_xfer) begin
              w_valid_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha2_msg_scheduler.sv
// Scoreboard bench for sha2_msg_scheduler: a 32-bit/64-round and a 64-bit/80-round instance,
// each driven through its own interface with a reference schedule model feeding a queue.
`timescale 1ns/1ps
module tb_sha2_msg_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start32 = 1'b0, clr32 = 1'b0, busy32, done32;
  logic start64 = 1'b0, clr64 = 1'b0, busy64, done64;

  sha2_msg_scheduler_if #(.WORD_W(32), .IDX_W(7)) b32 ();
  sha2_msg_scheduler_if #(.WORD_W(64), .IDX_W(7)) b64 ();

  sha2_msg_scheduler #(.WORD_W(32), .ROUNDS(64), .IDX_W(7)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .clr(clr32),
    .bus(b32), .busy(busy32), .blk_done(done32)
  );

  sha2_msg_scheduler #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .clr(clr64),
    .bus(b64), .busy(busy64), .blk_done(done64)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [6:0]  idx;
  } exp_t;

  exp_t        q32[$];
  exp_t        q64[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] blk [16];
  logic [63:0] seen32 [64];
  logic [63:0] seen64 [80];
  int          words32 = 0, words64 = 0;
  int          done_cnt32 = 0, done_cnt64 = 0;
  logic [6:0]  last_idx32 = '0, last_idx64 = '0;
  logic        stall32 = 1'b0, stall64 = 1'b0;
  logic [39:0] hold32;
  logic [71:0] hold64;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] bswap(input logic [63:0] x, input int bytes);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < bytes; b++) r[8*b +: 8] = x[8*(bytes-1-b) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rawWord(input int which, input logic [63:0] x);
`ifdef MSCHED_BSWAP_EN
    return bswap(x, (which == 0) ? 4 : 8);
`else
    return (which == 0) ? {32'h0, x[31:0]} : x;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // The reference schedule, written straight from the FIPS 180-4 recurrence.
  task automatic pushExpected(input int which);
    logic [63:0] w [80];
    logic [31:0] a32, b32v;
    logic [63:0] a64, b64v;
    exp_t        e;
    int          rounds;
    rounds = (which == 0) ? 64 : 80;
    for (int t = 0; t < 16; t++) begin
`ifdef MSCHED_BSWAP_EN
      w[t] = bswap(blk[t], (which == 0) ? 4 : 8);
`else
      w[t] = (which == 0) ? {32'h0, blk[t][31:0]} : blk[t];
`endif
    end
    for (int t = 16; t < rounds; t++) begin
      if (which == 0) begin
        a32  = w[t-2][31:0];
        b32v = w[t-15][31:0];
        w[t] = {32'h0, (rotr32(a32, 17) ^ rotr32(a32, 19) ^ (a32 >> 10)) + w[t-7][31:0]
                      + (rotr32(b32v, 7) ^ rotr32(b32v, 18) ^ (b32v >> 3)) + w[t-16][31:0]};
      end else begin
        a64  = w[t-2];
        b64v = w[t-15];
        w[t] = (rotr64(a64, 19) ^ rotr64(a64, 61) ^ (a64 >> 6)) + w[t-7]
             + (rotr64(b64v, 1) ^ rotr64(b64v, 8) ^ (b64v >> 7)) + w[t-16];
      end
    end
    for (int t = 0; t < rounds; t++) begin
      e.data = w[t];
      e.idx  = 7'(t);
      if (which == 0) q32.push_back(e);
      else            q64.push_back(e);
    end
  endtask

  task automatic consume(input int which, input logic [63:0] data, input logic [6:0] idx);
    exp_t e;
    int   n;
    n = (which == 0) ? q32.size() : q64.size();
    checkOutput((which == 0) ? "w32_expected_word" : "w64_expected_word", 64'(n != 0), 64'd1);
    if (n != 0) begin
      if (which == 0) e = q32.pop_front();
      else            e = q64.pop_front();
      checkOutput((which == 0) ? "w32_data" : "w64_data", data, e.data);
      checkOutput((which == 0) ? "w32_idx" : "w64_idx", 64'(idx), 64'(e.idx));
      if (which == 0) begin
        if (idx < 7'd64) seen32[idx] = data;
        last_idx32 = idx;
        words32++;
      end else begin
        if (idx < 7'd80) seen64[idx] = data;
        last_idx64 = idx;
        words64++;
      end
    end
  endtask

  // Consumer side: scoreboard pops, done pulses and stall-stability checks.
  always @(negedge clk) begin
    if (!rst) begin
      stall32 = 1'b0;
      stall64 = 1'b0;
    end else begin
      if (stall32 && !clr32)
        checkOutput("w32_stall_hold", 64'({b32.w_valid, b32.w_idx, b32.w_data}), 64'(hold32));
      if (stall64 && !clr64)
        checkOutput("w64_stall_hold", {b64.w_idx, b64.w_data}, hold64[63:0]);
      if (stall64 && !clr64)
        checkOutput("w64_stall_valid", 64'(b64.w_valid), 64'd1);
      if (b32.w_valid && b32.w_ready) consume(0, {32'h0, b32.w_data}, b32.w_idx);
      if (b64.w_valid && b64.w_ready) consume(1, b64.w_data, b64.w_idx);
      if (done32) done_cnt32++;
      if (done64) done_cnt64++;
      stall32 = b32.w_valid && !b32.w_ready;
      stall64 = b64.w_valid && !b64.w_ready;
      hold32  = {1'b1, b32.w_idx, b32.w_data};
      hold64  = {1'b1, b64.w_idx, b64.w_data};
    end
  end

  function automatic logic inValidOf(input int which);
    return (which == 0) ? b32.in_valid : b64.in_valid;
  endfunction
  function automatic logic inReadyOf(input int which);
    return (which == 0) ? b32.in_ready : b64.in_ready;
  endfunction
  function automatic logic wValidOf(input int which);
    return (which == 0) ? b32.w_valid : b64.w_valid;
  endfunction
  function automatic logic [6:0] wIdxOf(input int which);
    return (which == 0) ? b32.w_idx : b64.w_idx;
  endfunction
  function automatic logic busyOf(input int which);
    return (which == 0) ? busy32 : busy64;
  endfunction

  task automatic driveLoad(input int which, input logic v, input logic [63:0] d);
    if (which == 0) begin b32.in_valid = v; b32.in_data = d[31:0]; end
    else            begin b64.in_valid = v; b64.in_data = d;       end
  endtask
  task automatic driveReady(input int which, input logic r);
    if (which == 0) b32.w_ready = r;
    else            b64.w_ready = r;
  endtask
  task automatic driveStart(input int which, input logic s);
    if (which == 0) start32 = s;
    else            start64 = s;
  endtask
  task automatic driveClr(input int which, input logic c);
    if (which == 0) clr32 = c;
    else            clr64 = c;
  endtask

  task automatic loadAbc(input int which);
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = rawWord(which, (which == 0) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000);
    blk[15] = rawWord(which, 64'h18);
  endtask

  task automatic loadRandom();
    for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
  endtask

  // Runs one block; abort_kind 1 = async reset when w_idx reaches abort_at,
  // abort_kind 2 = clr once abort_at words have been loaded.
  task automatic applyStimulus(input int which, input int ready_pct, input int gap_pct,
                               input int abort_kind, input int abort_at, input int poke_idx);
    int   loaded, cycles, rounds;
    logic xfer, fin;
    loaded = 0;
    cycles = 0;
    fin    = 1'b0;
    rounds = (which == 0) ? 64 : 80;
    for (int i = 0; i < 64; i++) seen32[i] = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 80; i++) seen64[i] = 64'hDEAD_BEEF_DEAD_BEEF;
    pushExpected(which);
    if (which == 0) begin done_cnt32 = 0; words32 = 0; end
    else            begin done_cnt64 = 0; words64 = 0; end
    @(posedge clk); #1;
    driveStart(which, 1'b1);
    @(posedge clk); #1;
    driveStart(which, 1'b0);
    while (!fin && cycles < 3000) begin
      if (abort_kind == 2 && loaded == abort_at) begin
        driveLoad(which, 1'b0, '0);
        driveReady(which, 1'b1);
        driveClr(which, 1'b1);
        @(posedge clk); #1;
        driveClr(which, 1'b0);
        checkOutput("clr_busy", 64'(busyOf(which)), 64'd0);
        checkOutput("clr_w_valid", 64'(wValidOf(which)), 64'd0);
        if (which == 0) q32.delete(); else q64.delete();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("clr_stays_idle", 64'(busyOf(which)), 64'd0);
        fin = 1'b1;
      end else begin
        driveLoad(which, (loaded < 16) && ($urandom_range(0, 99) >= gap_pct),
                  (loaded < 16) ? blk[loaded] : 64'h0);
        driveReady(which, $urandom_range(0, 99) < ready_pct);
        @(negedge clk);
        xfer = inValidOf(which) && inReadyOf(which);
        @(posedge clk); #1;
        if (xfer) loaded++;
        cycles++;
        driveStart(which, (poke_idx >= 0) && wValidOf(which) && (int'(wIdxOf(which)) == poke_idx));
        if (abort_kind == 1 && wValidOf(which) && int'(wIdxOf(which)) == abort_at) begin
          rst = 1'b0;
          #1;
          if (which == 0) q32.delete(); else q64.delete();
          checkOutput("rst_mid_w_valid", 64'(wValidOf(which)), 64'd0);
          checkOutput("rst_mid_w_idx", 64'(wIdxOf(which)), 64'd0);
          checkOutput("rst_mid_w_data", (which == 0) ? 64'(b32.w_data) : b64.w_data, 64'd0);
          checkOutput("rst_mid_busy", 64'(busyOf(which)), 64'd0);
          driveLoad(which, 1'b0, '0);
          driveStart(which, 1'b0);
          @(posedge clk); #4;
          rst = 1'b1;
          fin = 1'b1;
        end else if (loaded == 16 && !busyOf(which)) begin
          fin = 1'b1;
        end
      end
    end
    driveStart(which, 1'b0);
    driveLoad(which, 1'b0, '0);
    driveReady(which, 1'b1);
    checkOutput((which == 0) ? "blk32_no_timeout" : "blk64_no_timeout", 64'(fin), 64'd1);
    if (abort_kind == 0) begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput((which == 0) ? "blk32_done_pulses" : "blk64_done_pulses",
                  64'((which == 0) ? done_cnt32 : done_cnt64), 64'd1);
      checkOutput((which == 0) ? "blk32_word_count" : "blk64_word_count",
                  64'((which == 0) ? words32 : words64), 64'(rounds));
      checkOutput((which == 0) ? "blk32_last_idx" : "blk64_last_idx",
                  64'((which == 0) ? last_idx32 : last_idx64), 64'(rounds - 1));
      checkOutput((which == 0) ? "blk32_queue_empty" : "blk64_queue_empty",
                  64'((which == 0) ? q32.size() : q64.size()), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    b32.in_valid = 1'b0; b32.in_data = '0; b32.w_ready = 1'b0;
    b64.in_valid = 1'b0; b64.in_data = '0; b64.w_ready = 1'b0;
    #2 rst = 1'b0;
    #10;
    checkOutput("reset_w_valid32", 64'(b32.w_valid), 64'd0);
    checkOutput("reset_w_data32", 64'(b32.w_data), 64'd0);
    checkOutput("reset_w_idx32", 64'(b32.w_idx), 64'd0);
    checkOutput("reset_busy32", 64'(busy32), 64'd0);
    checkOutput("reset_blk_done32", 64'(done32), 64'd0);
    checkOutput("reset_in_ready32", 64'(b32.in_ready), 64'd0);
    checkOutput("reset_w_valid64", 64'(b64.w_valid), 64'd0);
    checkOutput("reset_w_data64", b64.w_data, 64'd0);
    checkOutput("reset_busy64", 64'(busy64), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] SHA-256 abc block, no stalls");
    loadAbc(0);
    applyStimulus(0, 100, 0, 0, 0, -1);
    checkOutput("abc32_W0", seen32[0], 64'h6162_6380);
    checkOutput("abc32_W15", seen32[15], 64'h18);
    checkOutput("abc32_W16", seen32[16], 64'h6162_6380);
    checkOutput("abc32_W17", seen32[17], 64'h000F_0000);
    checkOutput("abc32_W18", seen32[18], 64'h7DA8_6405);

    $display("[TB] SHA-512 abc block, no stalls");
    loadAbc(1);
    applyStimulus(1, 100, 0, 0, 0, -1);
    checkOutput("abc64_W0", seen64[0], 64'h6162_6380_0000_0000);
    checkOutput("abc64_W16", seen64[16], 64'h6162_6380_0000_0000);
    checkOutput("abc64_W17", seen64[17], 64'h0003_0000_0000_00C0);

    $display("[TB] SHA-256 abc block, random stalls and gaps, start poked in EXPAND");
    loadAbc(0);
    applyStimulus(0, 50, 30, 0, 0, 30);
    checkOutput("stall32_W16", seen32[16], 64'h6162_6380);
    checkOutput("stall32_W18", seen32[18], 64'h7DA8_6405);

    $display("[TB] random blocks with stalls");
    loadRandom();
    applyStimulus(1, 60, 20, 0, 0, 40);
    loadRandom();
    applyStimulus(0, 70, 10, 0, 0, -1);

    $display("[TB] clr during LOAD");
    loadAbc(0);
    applyStimulus(0, 100, 0, 2, 7, -1);

    $display("[TB] async reset mid-block, then fresh block");
    loadAbc(0);
    applyStimulus(0, 70, 0, 1, 20, -1);
    loadAbc(0);
    applyStimulus(0, 100, 0, 0, 0, -1);
    checkOutput("post_rst_W0", seen32[0], 64'h6162_6380);
    checkOutput("post_rst_W16", seen32[16], 64'h6162_6380);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
